// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: decode to ALU op, forward operands, register.
// Holds on stall, bubbles on flush, clears asynchronously on reset.
module id_ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic        stall,
  input  logic        flush,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7b5,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  input  logic        exmem_regwrite,
  input  logic        memwb_regwrite,
  input  logic [4:0]  exmem_rd,
  input  logic [4:0]  memwb_rd,
  input  logic [31:0] exmem_result,
  input  logic [31:0] memwb_result,
  output logic        out_valid,
  output logic [31:0] A,
  output logic [31:0] B,
  output logic [2:0]  ALUControl,
  output logic [31:0] store_data,
  output logic [4:0]  rd_out,
  output logic        regwrite,
  output logic        is_load,
  output logic        is_store,
  output logic        is_branch,
  output logic [2:0]  branch_funct3,
  output logic        illegal
);

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLL = 3'b101;
  localparam logic [2:0] ALU_SRL = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic        hit1_ex, hit1_wb, hit2_ex, hit2_wb;
  logic [31:0] fwd1, fwd2;
  logic [2:0]  t_alu;
  logic        t_ok;
  logic [2:0]  d_alu;
  logic [31:0] d_a, d_b;
  logic        d_legal, d_writes, d_ld, d_st, d_br;
  logic        op_r, op_i, op_ld, op_st, op_br, op_lui, op_aui;

  assign hit1_ex = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs1);
  assign hit1_wb = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs1);
  assign hit2_ex = exmem_regwrite && (exmem_rd != 5'd0) && (exmem_rd == rs2);
  assign hit2_wb = memwb_regwrite && (memwb_rd != 5'd0) && (memwb_rd == rs2);

  assign fwd1 = hit1_ex ? exmem_result : hit1_wb ? memwb_result : rs1_data;
  assign fwd2 = hit2_ex ? exmem_result : hit2_wb ? memwb_result : rs2_data;

  assign op_r   = (opcode == OP_R);
  assign op_i   = (opcode == OP_I);
  assign op_ld  = (opcode == OP_LOAD);
  assign op_st  = (opcode == OP_STORE);
  assign op_br  = (opcode == OP_BR);
  assign op_lui = (opcode == OP_LUI);
  assign op_aui = (opcode == OP_AUIPC);

  // Shared funct3 table for register and immediate ALU ops.
  always_comb begin
    t_alu = ALU_ADD;
    t_ok  = 1'b1;
    unique case (funct3)
      3'b000: t_alu = ALU_ADD;
      3'b001: t_alu = ALU_SLL;
      3'b010: t_alu = ALU_SLT;
      3'b011: t_ok  = 1'b0;
      3'b100: t_alu = ALU_XOR;
      3'b101: begin
        t_alu = ALU_SRL;
        t_ok  = !funct7b5;
      end
      3'b110: t_alu = ALU_OR;
      3'b111: t_alu = ALU_AND;
    endcase
  end

  // Opcode decode: ALU op, operand select and class flags.
  always_comb begin
    d_alu    = ALU_ADD;
    d_a      = fwd1;
    d_b      = fwd2;
    d_legal  = 1'b1;
    d_writes = 1'b0;
    d_ld     = 1'b0;
    d_st     = 1'b0;
    d_br     = 1'b0;
    unique case (1'b1)
      op_r: begin
        d_alu    = (funct3 == 3'b000 && funct7b5) ? ALU_SUB : t_alu;
        d_legal  = t_ok;
        d_writes = 1'b1;
      end
      op_i: begin
        d_alu    = t_alu;
        d_legal  = t_ok;
        d_b      = imm;
        d_writes = 1'b1;
      end
      op_ld: begin
        d_b      = imm;
        d_ld     = 1'b1;
        d_writes = 1'b1;
      end
      op_st: begin
        d_b  = imm;
        d_st = 1'b1;
      end
      op_br: begin
        d_alu = ALU_SUB;
        d_br  = 1'b1;
      end
      op_lui: begin
        d_a      = 32'd0;
        d_b      = imm;
        d_writes = 1'b1;
      end
      op_aui: begin
        d_a      = pc;
        d_b      = imm;
        d_writes = 1'b1;
      end
      default: d_legal = 1'b0;
    endcase
    if (!d_legal) begin
      d_alu    = ALU_ADD;
      d_writes = 1'b0;
      d_ld     = 1'b0;
      d_st     = 1'b0;
      d_br     = 1'b0;
    end
  end

  // Pipeline register: reset/flush clear, stall holds, else capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      A             <= 32'd0;
      B             <= 32'd0;
      ALUControl    <= ALU_ADD;
      store_data    <= 32'd0;
      rd_out        <= 5'd0;
      regwrite      <= 1'b0;
      is_load       <= 1'b0;
      is_store      <= 1'b0;
      is_branch     <= 1'b0;
      branch_funct3 <= 3'd0;
      illegal       <= 1'b0;
    end else if (flush) begin
      out_valid     <= 1'b0;
      A             <= 32'd0;
      B             <= 32'd0;
      ALUControl    <= ALU_ADD;
      store_data    <= 32'd0;
      rd_out        <= 5'd0;
      regwrite      <= 1'b0;
      is_load       <= 1'b0;
      is_store      <= 1'b0;
      is_branch     <= 1'b0;
      branch_funct3 <= 3'd0;
      illegal       <= 1'b0;
    end else if (!stall) begin
      out_valid     <= in_valid;
      A             <= d_a;
      B             <= d_b;
      ALUControl    <= d_alu;
      store_data    <= fwd2;
      rd_out        <= rd;
      regwrite      <= in_valid && d_writes && (rd != 5'd0);
      is_load       <= in_valid && d_ld;
      is_store      <= in_valid && d_st;
      is_branch     <= in_valid && d_br;
      branch_funct3 <= funct3;
      illegal       <= in_valid && !d_legal;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage with an expectation queue.
// Each step pushes the expected register contents, then checks after the edge.
module tb_id_ex_stage;

  localparam logic [6:0] R  = 7'b0110011;
  localparam logic [6:0] I  = 7'b0010011;
  localparam logic [6:0] LD = 7'b0000011;
  localparam logic [6:0] ST = 7'b0100011;
  localparam logic [6:0] BR = 7'b1100011;
  localparam logic [6:0] LU = 7'b0110111;
  localparam logic [6:0] AU = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, stall, flush;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        funct7b5;
  logic [4:0]  rs1, rs2, rd;
  logic [31:0] rs1_data, rs2_data, imm, pc;
  logic        exmem_regwrite, memwb_regwrite;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic        out_valid;
  logic [31:0] A, B, store_data;
  logic [2:0]  ALUControl, branch_funct3;
  logic [4:0]  rd_out;
  logic        regwrite, is_load, is_store, is_branch, illegal;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .stall(stall), .flush(flush),
    .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .pc(pc),
    .exmem_regwrite(exmem_regwrite), .memwb_regwrite(memwb_regwrite),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_result(exmem_result), .memwb_result(memwb_result),
    .out_valid(out_valid), .A(A), .B(B), .ALUControl(ALUControl),
    .store_data(store_data), .rd_out(rd_out), .regwrite(regwrite),
    .is_load(is_load), .is_store(is_store), .is_branch(is_branch),
    .branch_funct3(branch_funct3), .illegal(illegal)
  );

  typedef struct {
    bit          full;
    logic        v;
    logic [31:0] a, b;
    logic [2:0]  alu;
    logic        rw, ill, ld, st, br;
    logic [4:0]  rd;
    logic [31:0] sd;
    logic [2:0]  bf;
  } exp_t;

  exp_t q[$];
  int compared = 0;
  int mismatched = 0;

  function automatic exp_t mk(
    input bit full, input logic v,
    input logic [31:0] a, input logic [31:0] b,
    input logic [2:0] alu, input logic rw, input logic ill,
    input logic ld, input logic st, input logic br,
    input logic [4:0] d, input logic [31:0] sd, input logic [2:0] bf);
    exp_t e;
    e.full = full; e.v = v; e.a = a; e.b = b; e.alu = alu;
    e.rw = rw; e.ill = ill; e.ld = ld; e.st = st; e.br = br;
    e.rd = d; e.sd = sd; e.bf = bf;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    compared++;
    assert (q.size() > 0) else begin
      mismatched++;
      $error("FAIL %s.queue observed=empty expected=entry", tag);
    end
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({tag, ".valid"}, {31'd0, out_valid}, {31'd0, e.v});
      chk({tag, ".alu"}, {29'd0, ALUControl}, {29'd0, e.alu});
      chk({tag, ".regwrite"}, {31'd0, regwrite}, {31'd0, e.rw});
      chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, e.ill});
      chk({tag, ".is_load"}, {31'd0, is_load}, {31'd0, e.ld});
      chk({tag, ".is_store"}, {31'd0, is_store}, {31'd0, e.st});
      chk({tag, ".is_branch"}, {31'd0, is_branch}, {31'd0, e.br});
      if (e.full) begin
        chk({tag, ".A"}, A, e.a);
        chk({tag, ".B"}, B, e.b);
        chk({tag, ".rd_out"}, {27'd0, rd_out}, {27'd0, e.rd});
        chk({tag, ".store_data"}, store_data, e.sd);
        chk({tag, ".bf3"}, {29'd0, branch_funct3}, {29'd0, e.bf});
      end
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    #1;
    check_out(tag);
  endtask

  task automatic ins(input logic [6:0] op, input logic [2:0] f3,
                     input logic f7, input logic [4:0] r1,
                     input logic [4:0] r2, input logic [4:0] d,
                     input logic [31:0] x1, input logic [31:0] x2,
                     input logic [31:0] im, input logic [31:0] p);
    in_valid = 1'b1; opcode = op; funct3 = f3; funct7b5 = f7;
    rs1 = r1; rs2 = r2; rd = d;
    rs1_data = x1; rs2_data = x2; imm = im; pc = p;
  endtask

  task automatic no_fwd();
    exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    exmem_result = 32'd0; memwb_result = 32'd0;
  endtask

  exp_t z, x;
  logic [2:0] f3s [7];
  logic [2:0] alus [7];

  initial begin
    f3s  = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd6, 3'd7};
    alus = '{3'd0, 3'd5, 3'd7, 3'd4, 3'd6, 3'd3, 3'd2};
    z = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
    ins(R, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    no_fwd();
    repeat (2) @(posedge clk);
    #1;
    q.push_back(z); check_out("reset");
    @(negedge clk) rst_n = 1'b1;

    ins(R, 0, 1, 1, 2, 3, 7, 9, 0, 0);
    q.push_back(mk(1, 1, 7, 9, 1, 1, 0, 0, 0, 0, 3, 9, 0));
    step("sub");

    for (int i = 0; i < 7; i++) begin
      ins(R, f3s[i], 0, 1, 2, 5'(i + 1), 32'(i * 3 + 1),
          32'(i * 5 + 2), 0, 0);
      q.push_back(mk(1, 1, 32'(i * 3 + 1), 32'(i * 5 + 2), alus[i],
                     1, 0, 0, 0, 0, 5'(i + 1), 32'(i * 5 + 2), f3s[i]));
      step("rtab");
    end

    ins(I, 0, 1, 1, 0, 6, 32'h10, 32'h999, 32'hFFFF_FFF0, 0);
    q.push_back(mk(1, 1, 32'h10, 32'hFFFF_FFF0, 0, 1, 0, 0, 0, 0,
                   6, 32'h999, 0));
    step("addi");

    ins(LD, 2, 0, 1, 0, 7, 32'h1000, 0, 8, 0);
    q.push_back(mk(1, 1, 32'h1000, 8, 0, 1, 0, 1, 0, 0, 7, 0, 2));
    step("load");

    ins(ST, 2, 0, 1, 6, 0, 32'h2000, 32'h55, 4, 0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'hABCD;
    q.push_back(mk(1, 1, 32'h2000, 4, 0, 0, 0, 0, 1, 0, 0,
                   32'hABCD, 2));
    step("store_fwd");
    no_fwd();

    ins(BR, 1, 0, 1, 2, 5, 3, 3, 0, 0);
    q.push_back(mk(1, 1, 3, 3, 1, 0, 0, 0, 0, 1, 5, 3, 1));
    step("branch");

    ins(R, 0, 0, 5, 0, 8, 32'h99, 1, 0, 0);
    exmem_regwrite = 1'b1; exmem_rd = 5'd5; exmem_result = 32'h11;
    memwb_regwrite = 1'b1; memwb_rd = 5'd5; memwb_result = 32'h22;
    q.push_back(mk(1, 1, 32'h11, 1, 0, 1, 0, 0, 0, 0, 8, 1, 0));
    step("fwd_exmem");
    exmem_regwrite = 1'b0;
    q.push_back(mk(1, 1, 32'h22, 1, 0, 1, 0, 0, 0, 0, 8, 1, 0));
    step("fwd_memwb");
    exmem_regwrite = 1'b1; rs1 = 5'd0;
    exmem_rd = 5'd0; memwb_rd = 5'd0;
    q.push_back(mk(1, 1, 32'h99, 1, 0, 1, 0, 0, 0, 0, 8, 1, 0));
    step("fwd_x0");
    no_fwd();

    ins(LU, 0, 0, 3, 4, 0, 32'h77, 32'h88, 32'h1234_5000, 32'h40);
    q.push_back(mk(1, 1, 0, 32'h1234_5000, 0, 0, 0, 0, 0, 0, 0,
                   32'h88, 0));
    step("lui");

    ins(AU, 0, 0, 3, 4, 9, 32'h77, 32'h88, 32'h2000, 32'h100);
    q.push_back(mk(1, 1, 32'h100, 32'h2000, 0, 1, 0, 0, 0, 0, 9,
                   32'h88, 0));
    step("auipc");

    ins(R, 4, 0, 1, 2, 10, 32'hA, 32'hC, 0, 0);
    x = mk(1, 1, 32'hA, 32'hC, 4, 1, 0, 0, 0, 0, 10, 32'hC, 4);
    q.push_back(x);
    step("pre_stall");
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins(LD, 3'(i), 1, 5'(i + 2), 3, 5'(i + 20), 32'(i + 100),
          32'hDEAD, 32'(i), 32'h500);
      exmem_regwrite = 1'b1; exmem_rd = 5'(i + 2);
      exmem_result = 32'hBEEF;
      q.push_back(x);
      step("stall");
    end
    flush = 1'b1;
    q.push_back(z);
    step("stall_flush");
    stall = 1'b0; flush = 1'b0;
    no_fwd();
    ins(R, 0, 1, 1, 2, 11, 20, 5, 0, 0);
    q.push_back(mk(1, 1, 20, 5, 1, 1, 0, 0, 0, 0, 11, 5, 0));
    step("post_stall");

    flush = 1'b1;
    ins(LD, 2, 0, 1, 2, 12, 1, 2, 3, 0);
    q.push_back(z);
    step("flush");
    flush = 1'b0;

    in_valid = 1'b0;
    q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    step("bubble");

    ins(R, 0, 0, 1, 2, 0, 4, 4, 0, 0);
    q.push_back(mk(1, 1, 4, 4, 0, 0, 0, 0, 0, 0, 0, 4, 0));
    step("rd0");

    ins(R, 5, 1, 1, 2, 13, 4, 4, 0, 0);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("ill_sra");
    ins(I, 5, 1, 1, 2, 13, 4, 4, 32'h405, 0);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("ill_srai");
    ins(R, 3, 0, 1, 2, 13, 4, 4, 0, 0);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("ill_sltu");
    ins(7'h7F, 4, 0, 1, 2, 13, 4, 4, 0, 0);
    q.push_back(mk(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    step("ill_op");

    ins(R, 0, 0, 1, 2, 12, 1, 2, 0, 0);
    q.push_back(mk(1, 1, 1, 2, 0, 1, 0, 0, 0, 0, 12, 2, 0));
    step("pre_rst");
    #2 rst_n = 1'b0;
    #1;
    q.push_back(z); check_out("rst_async");
    @(posedge clk); #1;
    q.push_back(z); check_out("rst_held");
    @(negedge clk) rst_n = 1'b1;
    #1;
    q.push_back(z); check_out("rst_release");
    q.push_back(mk(1, 1, 1, 2, 0, 1, 0, 0, 0, 0, 12, 2, 0));
    step("post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage of the 32-bit RISC-V core, directly upstream of the ALU. Each cycle it decodes the issued instruction into the 3-bit ALU operation code, selects and forwards operands A and B, and registers them together with the writeback controls, so the ALU sees stable A/B/ALUControl for one full cycle. It supports pipeline stall, flush and EX/MEM, MEM/WB forwarding.

## Interface
- No parameters; data width is fixed at 32, register index width at 5.
- Clock and reset: one clock; reset is asynchronous and active-low.
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  decode stage presents a valid instruction
- stall  in  1  hold all registered outputs
- flush  in  1  squash the stage contents and insert a bubble
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7b5  in  1  instruction[30]
- rs1, rs2, rd  in  5 each  register indices
- rs1_data, rs2_data  in  32 each  register file read data
- imm  in  32  sign-extended immediate from decode
- pc  in  32  instruction address
- exmem_regwrite, memwb_regwrite  in  1 each  older instruction writes a register
- exmem_rd, memwb_rd  in  5 each  destination of that instruction
- exmem_result, memwb_result  in  32 each  value to be written
- out_valid  out  1  registered contents are a real instruction
- A, B  out  32 each  ALU operands
- ALUControl  out  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SLT
- store_data  out  32  forwarded rs2 value for stores
- rd_out  out  5  destination index
- regwrite  out  1  writeback enable
- is_load, is_store, is_branch  out  1 each  class flags for downstream stages
- branch_funct3  out  3  funct3, passed through for branch resolution
- illegal  out  1  unsupported instruction encoding

## Operation
- Decode, by opcode:
  - 0110011 R-type:
    - funct3 000 → SUB if funct7b5=1, else ADD.
    - 001 SLL; 010 SLT; 100 XOR; 101 SRL; 110 OR; 111 AND.
    - 101 with funct7b5=1 (SRA) and 011 (SLTU) → illegal.
    - B = forwarded rs2.
  - 0010011 I-type ALU: same table as R-type, except funct3 000 is always ADD; B = imm.
  - 0000011 load: ADD, B = imm, is_load.
  - 0100011 store: ADD, B = imm, is_store, regwrite=0.
  - 1100011 branch: SUB, B = forwarded rs2, is_branch, regwrite=0.
  - 0110111 LUI: ADD, A = 0, B = imm.
  - 0010111 AUIPC: ADD, A = pc, B = imm.
  - Any other opcode → illegal.
- A is forwarded rs1 except for LUI and AUIPC.
- Forwarding is evaluated per source index at capture time. Priority:
  1. exmem_regwrite && exmem_rd≠0 && exmem_rd==rsN → exmem_result;
  2. memwb_regwrite && memwb_rd≠0 && memwb_rd==rsN → memwb_result;
  3. otherwise rsN_data.
- Index 0 is never forwarded.
- regwrite = 1 for R-type, I-type, load, LUI and AUIPC, and only when rd≠0 and the encoding is legal.
- An illegal instruction registers out_valid=1, illegal=1, regwrite=0, is_load=is_store=is_branch=0, ALUControl=000.

## Timing
- Latency 1 cycle: inputs sampled on a rising clk edge appear on the outputs after that edge.
- Normal edge (no stall, no flush):
  - out_valid ← in_valid;
  - all other outputs ← decoded and forwarded values.
  - When in_valid=0: regwrite, is_load, is_store, is_branch and illegal register as 0; data outputs may update.
- stall=1: every output holds its value; forwarding inputs are ignored that cycle.
- flush=1: out_valid, regwrite, is_load, is_store, is_branch and illegal ← 0; data outputs ← 0.
- Flush has priority over stall when both are asserted.
- rst_n=0, at any time and asynchronously: every output ← 0. This is equivalent to a bubble carrying ADD with A=B=0.
- Deassertion of rst_n is applied at the next clock edge; the first capture occurs at the first rising edge with rst_n=1.
- No combinational path from inputs to outputs.

## Test plan
- Reset mid-stream: drive a valid ADD, pull rst_n low between edges → all outputs 0 immediately, out_valid=0, and they stay 0 until the first edge after release.
- R-type SUB (funct3 000, funct7b5=1), rs1_data=7, rs2_data=9, rd=3 → next edge: ALUControl=001, A=7, B=9, regwrite=1, rd_out=3.
- Forwarding: rs1=5 with exmem_rd=5 (result 0x11) and memwb_rd=5 (result 0x22) → A=0x11. Then exmem_regwrite=0 → A=0x22. Then rs1=0 with both *_rd=0 → A=rs1_data.
- LUI imm=0x12345000, rd=0 → A=0, B=0x12345000, ALUControl=000, regwrite=0. AUIPC pc=0x100, imm=0x2000 → A=0x100, B=0x2000.
- Stall/flush:
  - stall=1 for 3 cycles while inputs change → outputs unchanged.
  - stall=1 and flush=1 together → out_valid=0, regwrite=0.
  - Next unstalled valid instruction is captured normally.
- Illegal encodings: SRA (funct3 101, funct7b5=1) and opcode 1111111 → out_valid=1, illegal=1, regwrite=0, ALUControl=000.
